// File: rtl/axis_rx_pkt_buffer.sv
// axis_rx_pkt_buffer
//
// Store-and-forward packet buffer for the 32-bit receive AXI-Stream.
// Words are written speculatively. A packet becomes visible to the reader
// only after its tlast word is written, so the consumer never sees a partial
// packet. Packets that overflow the buffer, are longer than MAX_PKT_WORDS,
// or are flagged with s_pkt_drop on their tlast beat are discarded whole.
// The input never applies backpressure: once out of reset, s_axis_tready
// stays high and the buffer drops packets instead of stalling.
//
// Ports:
//   aclk, areset          clock, asynchronous active-high reset
//   s_axis_t*             input stream (tdata/tvalid/tlast/tready)
//   s_pkt_drop            sampled with the tlast beat, 1 discards the packet
//   m_axis_t*             output stream of committed packets
//   pkt_count             committed packets, saturating
//   drop_count            discarded packets, saturating
//   buf_empty             no committed word is left unread
module axis_rx_pkt_buffer #(
    parameter int DEPTH         = 512,
    parameter int MAX_PKT_WORDS = 384
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    input  logic        s_pkt_drop,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [15:0] pkt_count,
    output logic [15:0] drop_count,
    output logic        buf_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
    localparam logic [PW-1:0] MAX_LEN_P = PW'(MAX_PKT_WORDS);

    typedef enum logic [1:0] {IDLE, WRITE, DISCARD} wr_state_t;

    wr_state_t     state;
    logic [32:0]   mem [DEPTH];
    logic [32:0]   rdata;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] cm_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] len;
    logic [PW-1:0] free;

    logic          beat;
    logic          in_pkt;
    logic          no_room;
    logic          rule_a;
    logic          rule_b;
    logic          wr_en;
    logic          commit;
    logic          drop_evt;

    logic          rd_en;
    logic          rd_valid;
    logic          skid_valid;
    logic [32:0]   skid;
    logic          out_fire;

    // Free space is measured against the registered read pointer, so it can
    // understate the true space by the word being read this cycle.
    assign free = DEPTH_P - (wr_ptr - rd_ptr);

    // In IDLE nothing of the packet is stored yet, so only a full buffer can
    // reject the first beat; the length limit applies from the second beat.
    assign beat     = s_axis_tvalid && s_axis_tready;
    assign in_pkt   = beat && (state != DISCARD);
    assign no_room  = (free == '0) || ((state == WRITE) && (len == MAX_LEN_P));
    assign rule_a   = in_pkt && no_room;
    assign rule_b   = in_pkt && !no_room && s_axis_tlast && s_pkt_drop;
    assign wr_en    = in_pkt && !no_room && !(s_axis_tlast && s_pkt_drop);
    assign commit   = wr_en && s_axis_tlast;
    assign drop_evt = (rule_a && s_axis_tlast) || rule_b ||
                      (beat && (state == DISCARD) && s_axis_tlast);

    // Write FSM, commit/rollback of the speculative pointer and counters.
    // A rejected packet rolls wr_ptr back to cm_ptr, freeing its words.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            cm_ptr        <= '0;
            len           <= '0;
            pkt_count     <= '0;
            drop_count    <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            s_axis_tready <= 1'b1;
            if (rule_a || rule_b) begin
                wr_ptr <= cm_ptr;
                state  <= (rule_a && !s_axis_tlast) ? DISCARD : IDLE;
            end else if (commit) begin
                wr_ptr <= wr_ptr + PW'(1);
                cm_ptr <= wr_ptr + PW'(1);
                state  <= IDLE;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
                len    <= (state == IDLE) ? PW'(1) : len + PW'(1);
                state  <= WRITE;
            end else if (beat && (state == DISCARD) && s_axis_tlast) begin
                state <= IDLE;
            end
            if (commit && (pkt_count != 16'hFFFF)) begin
                pkt_count <= pkt_count + 16'd1;
            end
            if (drop_evt && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Packet memory: {tlast, data} words, synchronous read.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
        if (rd_en) begin
            rdata <= mem[rd_ptr[AW-1:0]];
        end
    end

    // A read is issued only when its data is sure to find a slot: the skid
    // is empty and either nothing is held/in flight or the output is being
    // accepted. While the output is stalled at most one word leaves memory.
    assign out_fire = m_axis_tvalid && m_axis_tready;
    assign rd_en    = (rd_ptr != cm_ptr) && !skid_valid &&
                      (!(m_axis_tvalid || rd_valid) || m_axis_tready);

    // Output stage: the memory read result goes to the output register, or
    // into the skid when the output is stalled. The skid always drains first.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_ptr        <= '0;
            rd_valid      <= 1'b0;
            skid_valid    <= 1'b0;
            skid          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (out_fire || !m_axis_tvalid) begin
                if (skid_valid) begin
                    {m_axis_tlast, m_axis_tdata} <= skid;
                    m_axis_tvalid                <= 1'b1;
                    skid_valid                   <= 1'b0;
                end else if (rd_valid) begin
                    {m_axis_tlast, m_axis_tdata} <= rdata;
                    m_axis_tvalid                <= 1'b1;
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end else if (rd_valid) begin
                skid       <= rdata;
                skid_valid <= 1'b1;
            end
        end
    end

    assign buf_empty = (rd_ptr == cm_ptr) && !rd_valid && !skid_valid && !m_axis_tvalid;

endmodule

// File: tb/tb_axis_rx_pkt_buffer.sv
// tb_axis_rx_pkt_buffer
//
// Testbench for axis_rx_pkt_buffer. Stimulus tasks send packets and decide,
// from the packet-level rules (drop flag, length limit, room left in the
// buffer), whether each packet should be delivered; delivered words are
// pushed into a scoreboard queue. A separate monitor pops and compares every
// accepted output word and checks that stalled outputs stay stable.
module tb_axis_rx_pkt_buffer;

    localparam int DEPTH         = 512;
    localparam int MAX_PKT_WORDS = 384;

    logic        aclk;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        s_pkt_drop;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;
    logic        buf_empty;

    int          checks = 0;
    int          errors = 0;
    int          exp_pkts = 0;
    int          exp_drops = 0;
    int          ready_mode = 0;
    logic [32:0] exp_q[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    axis_rx_pkt_buffer #(
        .DEPTH(DEPTH),
        .MAX_PKT_WORDS(MAX_PKT_WORDS)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .s_pkt_drop(s_pkt_drop),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .pkt_count(pkt_count),
        .drop_count(drop_count),
        .buf_empty(buf_empty)
    );

    // 100 MHz clock.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Downstream ready: held low, held high, or random 50% per cycle.
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (ready_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: sampled on the falling edge, between driver updates.
    always @(negedge aclk) begin
        logic [32:0] exp_word;
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tlast == prev_last)) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got valid=%0b data=%h last=%0b, required valid=1 data=%h last=%0b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_word: got data=%h last=%0b, required no output",
                             m_axis_tdata, m_axis_tlast);
                end else begin
                    exp_word = exp_q.pop_front();
                    if ({m_axis_tlast, m_axis_tdata} !== exp_word) begin
                        errors++;
                        $display("[TB] FAIL out_word: got data=%h last=%0b, required data=%h last=%0b",
                                 m_axis_tdata, m_axis_tlast, exp_word[31:0], exp_word[32]);
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic idleCycle();
        @(posedge aclk);
        #1;
    endtask

    // One input beat, held until the buffer shows ready (bounded).
    task automatic sendBeat(input logic [31:0] d, input logic last, input logic drp);
        int waited = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_pkt_drop    = drp & last;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_axis_tready && waited < 50) begin
            waited++;
            @(negedge aclk);
        end
        if (!s_axis_tready) begin
            checks++;
            errors++;
            $display("[TB] FAIL tready_timeout: got tready=0, required 1");
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_pkt_drop    = 1'b0;
    endtask

    // Sends one packet and records the expected outcome. A packet is
    // delivered unless it is flagged, too long, or cannot fit alongside the
    // words still waiting to be read.
    task automatic applyStimulus(input int len, input bit drp, input int gap_pct,
                                 input bit seq, input logic [31:0] base);
        logic [32:0] words[$];
        logic [31:0] w;
        bit          deliver;
        for (int i = 0; i < len; i++) begin
            while ($urandom_range(0, 99) < gap_pct) idleCycle();
            w = seq ? base + 32'(i) : $urandom;
            words.push_back({(i == len - 1), w});
            if (i == len - 1) begin
                deliver = !drp && (len <= MAX_PKT_WORDS) && (exp_q.size() + len <= DEPTH);
                if (deliver) begin
                    foreach (words[k]) exp_q.push_back(words[k]);
                    if (exp_pkts < 65535) exp_pkts++;
                end else begin
                    if (exp_drops < 65535) exp_drops++;
                end
            end
            sendBeat(w, (i == len - 1), drp);
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            idleCycle();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
        end
        repeat (6) idleCycle();
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkts));
        checkOutput({tag, "_drop_count"}, 32'(drop_count), 32'(exp_drops));
    endtask

    initial begin
        areset        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_pkt_drop    = 1'b0;

        // Reset state.
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_tready", 32'(s_axis_tready), 32'd0);
        checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("rst_tdata", m_axis_tdata, 32'd0);
        checkOutput("rst_buf_empty", 32'(buf_empty), 32'd1);
        checkCounters("rst");
        areset = 1'b0;
        idleCycle();
        checkOutput("post_rst_tready", 32'(s_axis_tready), 32'd1);

        // Three 4-word packets, data 1..12, downstream always ready.
        $display("[TB] three back-to-back packets");
        ready_mode = 1;
        for (int p = 0; p < 3; p++) applyStimulus(4, 0, 0, 1, 32'(4 * p + 1));
        waitDrain(200);
        checkCounters("basic");
        checkOutput("basic_buf_empty", 32'(buf_empty), 32'd1);

        // Flagged packet is dropped, the following good packet is delivered.
        $display("[TB] flagged drop");
        applyStimulus(5, 1, 0, 1, 32'h0000_0100);
        applyStimulus(2, 0, 0, 1, 32'h0000_0200);
        waitDrain(200);
        checkCounters("flag");

        // Overflow with downstream stalled: the second packet cannot fit.
        $display("[TB] overflow while stalled");
        ready_mode = 0;
        idleCycle();
        applyStimulus(320, 0, 0, 1, 32'h0001_0000);
        applyStimulus(250, 0, 0, 1, 32'h0002_0000);
        repeat (10) idleCycle();
        checkCounters("ovf");
        checkOutput("ovf_tvalid_held", 32'(m_axis_tvalid), 32'd1);
        checkOutput("ovf_buf_empty", 32'(buf_empty), 32'd0);
        ready_mode = 1;
        waitDrain(2000);
        checkOutput("ovf_buf_empty_end", 32'(buf_empty), 32'd1);

        // Length limit: one word too many is dropped, exactly the limit passes.
        $display("[TB] length limit");
        applyStimulus(400, 0, 0, 1, 32'h0003_0000);
        applyStimulus(384, 0, 0, 1, 32'h0004_0000);
        waitDrain(2000);
        checkCounters("maxlen");

        // Random traffic with random downstream ready; pointers wrap.
        $display("[TB] random traffic");
        ready_mode = 2;
        for (int p = 0; p < 200; p++) begin
            applyStimulus($urandom_range(1, 16), ($urandom_range(0, 4) == 0), 40, 0, 32'd0);
        end
        ready_mode = 1;
        waitDrain(5000);
        checkCounters("rand");
        checkOutput("rand_buf_empty", 32'(buf_empty), 32'd1);

        // Reset in the middle of a packet, with a stalled word at the output.
        $display("[TB] reset mid-packet");
        ready_mode = 0;
        idleCycle();
        applyStimulus(4, 0, 0, 1, 32'h0000_00A0);
        repeat (5) idleCycle();
        checkOutput("prerst_tvalid", 32'(m_axis_tvalid), 32'd1);
        sendBeat(32'h0000_00B1, 1'b0, 1'b0);
        sendBeat(32'h0000_00B2, 1'b0, 1'b0);
        s_axis_tdata  = 32'h0000_00B3;
        s_axis_tvalid = 1'b1;
        areset        = 1'b1;
        #1;
        exp_q.delete();
        exp_pkts  = 0;
        exp_drops = 0;
        checkOutput("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("midrst_tlast", 32'(m_axis_tlast), 32'd0);
        checkOutput("midrst_tdata", m_axis_tdata, 32'd0);
        checkOutput("midrst_tready", 32'(s_axis_tready), 32'd0);
        checkOutput("midrst_buf_empty", 32'(buf_empty), 32'd1);
        checkCounters("midrst");
        repeat (2) @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        areset        = 1'b0;
        ready_mode    = 1;
        applyStimulus(3, 0, 0, 1, 32'h0000_00B4);
        applyStimulus(6, 0, 0, 1, 32'h0000_00C1);
        waitDrain(200);
        checkCounters("postrst");
        checkOutput("postrst_buf_empty", 32'(buf_empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
